// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers: gray/binary conversion and reset flag values.
// Pure types/functions, no latency; no flow control involved.
// Narrower pointers are zero-extended into ptr_t, which leaves both conversions exact.
package fifo_pkg;

  // Widest supported FIFO pointer.
  localparam int PTR_W = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam logic RST_FULL  = 1'b0;
  localparam logic RST_EMPTY = 1'b1;

  function automatic ptr_t gray_to_bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin_to_gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Generic N-stage multi-bit flop synchronizer with async active-low reset.
// Latency: STAGES edges from first sample to o_q; always accepts, no backpressure.
// Input must change at most one bit per source cycle (gray pointers) for a coherent result.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Async-FIFO pointer receiver: syncs the remote gray pointer, makes full/empty and fill level.
// Latency: remote moves reach the flag after SYNC_STAGES+1 edges; local moves after one edge.
// Flag is pessimistic; FIFO_ALMOST_FLAG_EN adds a registered o_almost flag.
module gray_ptr_receiver
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter bit WRITE_SIDE    = 1'b1,
  parameter int ALMOST_THRESH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH:0]   i_remote_ptr,
  input  logic [ADDR_WIDTH:0]   i_local_ptr,
  input  logic [ADDR_WIDTH:0]   i_local_gray_next,
  output logic                  o_status,
  output logic [ADDR_WIDTH:0]   o_remote_bin,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_almost
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_receiver: SYNC_STAGES must be 2..4");
  end
  if (ADDR_WIDTH < 2 || PW > PTR_W) begin : g_bad_width
    $error("gray_ptr_receiver: ADDR_WIDTH out of supported range");
  end
  if (ALMOST_THRESH < 0 || ALMOST_THRESH > DEPTH) begin : g_bad_thresh
    $error("gray_ptr_receiver: ALMOST_THRESH must be 0..2**ADDR_WIDTH");
  end

  logic [PW-1:0] r_sync;
  logic [PW-1:0] remote_bin;
  logic [PW-1:0] local_bin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;
  logic          status_next;
  logic          r_status;
  logic [PW-1:0] r_level;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_remote_ptr),
    .o_q     (r_sync)
  );

  assign remote_bin = PW'(gray_to_bin(PTR_W'(r_sync)));
  assign local_bin  = PW'(gray_to_bin(PTR_W'(i_local_ptr)));

  // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
  assign full_cmp    = {~r_sync[PW-1 -: 2], r_sync[PW-3:0]};
  assign status_next = WRITE_SIDE ? (i_local_gray_next == full_cmp)
                                  : (i_local_gray_next == r_sync);
  assign level_next  = WRITE_SIDE ? (local_bin - remote_bin) : (remote_bin - local_bin);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status <= WRITE_SIDE ? RST_FULL : RST_EMPTY;
      r_level  <= '0;
    end else begin
      r_status <= status_next;
      r_level  <= level_next;
    end
  end

  assign o_status     = r_status;
  assign o_level      = r_level;
  assign o_remote_bin = remote_bin;

`ifdef FIFO_ALMOST_FLAG_EN
  localparam logic [PW-1:0] ALMOST_HI = PW'(DEPTH - ALMOST_THRESH);
  localparam logic [PW-1:0] ALMOST_LO = PW'(ALMOST_THRESH);

  logic almost_next;
  logic r_almost;

  assign almost_next = WRITE_SIDE ? (level_next >= ALMOST_HI) : (level_next <= ALMOST_LO);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_almost <= 1'b0;
    end else begin
      r_almost <= almost_next;
    end
  end

  assign o_almost = r_almost;
`else
  assign o_almost = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Bench for gray_ptr_receiver: write-side and read-side instances, table vectors,
// hand sequences for latency/full/simultaneous cases, then a random FIFO walk vs a pointer-history model.
module tb_gray_ptr_receiver;

  localparam int S = 2;
  localparam int T = 1;
`ifdef FIFO_ALMOST_FLAG_EN
  localparam bit ALM_EN = 1'b1;
`else
  localparam bit ALM_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] wr_remote = '0, wr_local = '0, wr_next = '0;
  logic [3:0] rd_remote = '0, rd_local = '0, rd_next = '0;
  logic       wr_status, rd_status, wr_almost, rd_almost;
  logic [3:0] wr_rbin, rd_rbin, wr_level, rd_level;

  always #5 i_clk = ~i_clk;

  gray_ptr_receiver #(.ADDR_WIDTH(3), .SYNC_STAGES(S), .WRITE_SIDE(1'b1), .ALMOST_THRESH(T)) dut_wr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_remote_ptr(wr_remote), .i_local_ptr(wr_local),
    .i_local_gray_next(wr_next), .o_status(wr_status), .o_remote_bin(wr_rbin),
    .o_level(wr_level), .o_almost(wr_almost));

  gray_ptr_receiver #(.ADDR_WIDTH(3), .SYNC_STAGES(S), .WRITE_SIDE(1'b0), .ALMOST_THRESH(T)) dut_rd (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_remote_ptr(rd_remote), .i_local_ptr(rd_local),
    .i_local_gray_next(rd_next), .o_status(rd_status), .o_remote_bin(rd_rbin),
    .o_level(rd_level), .o_almost(rd_almost));

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] rb, lb, nb;
    logic       st_wr;
    logic [3:0] lv_wr;
    logic       st_rd;
    logic [3:0] lv_rd;
  } vec_t;
  vec_t tbl [8];

  logic [3:0] hist_wr [0:1023];
  logic [3:0] hist_rd [0:1023];

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] wr_r, wr_l, wr_n, rd_r, rd_l, rd_n);
    wr_remote = b2g(wr_r); wr_local = b2g(wr_l); wr_next = b2g(wr_n);
    rd_remote = b2g(rd_r); rd_local = b2g(rd_l); rd_next = b2g(rd_n);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_status"}, wr_status, 0);
    check({tag, "_rd_status"}, rd_status, 1);
    check({tag, "_wr_level"}, wr_level, 0);
    check({tag, "_rd_level"}, rd_level, 0);
    check({tag, "_wr_rbin"}, wr_rbin, 0);
    check({tag, "_rd_rbin"}, rd_rbin, 0);
    check({tag, "_wr_almost"}, wr_almost, 0);
    check({tag, "_rd_almost"}, rd_almost, 0);
  endtask

  initial begin
    logic [3:0] wr_bin, rd_bin, diff, rbw, raw, rbr, rar, nxw, nxr, lvw, lvr;
    logic       wr_inc, rd_inc;
    int         n;

    // remote, local, next (binary) -> write-side / read-side expectations
    tbl[0] = '{4'd0,  4'd0, 4'd0, 1'b0, 4'd0,  1'b1, 4'd0};
    tbl[1] = '{4'd0,  4'd7, 4'd8, 1'b1, 4'd7,  1'b0, 4'd9};
    tbl[2] = '{4'd0,  4'd8, 4'd8, 1'b1, 4'd8,  1'b0, 4'd8};
    tbl[3] = '{4'd14, 4'd2, 4'd3, 1'b0, 4'd4,  1'b0, 4'd12};
    tbl[4] = '{4'd5,  4'd5, 4'd6, 1'b0, 4'd0,  1'b0, 4'd0};
    tbl[5] = '{4'd5,  4'd4, 4'd5, 1'b0, 4'd15, 1'b1, 4'd1};
    tbl[6] = '{4'd9,  4'd1, 4'd1, 1'b1, 4'd8,  1'b0, 4'd8};
    tbl[7] = '{4'd15, 4'd15, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0};

    #12;
    check_reset("por");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rb, tbl[i].lb, tbl[i].nb, tbl[i].rb, tbl[i].lb, tbl[i].nb);
      repeat (3) step();
      check($sformatf("tbl%0d_wr_status", i), wr_status, tbl[i].st_wr);
      check($sformatf("tbl%0d_wr_level", i), wr_level, tbl[i].lv_wr);
      check($sformatf("tbl%0d_wr_rbin", i), wr_rbin, tbl[i].rb);
      check($sformatf("tbl%0d_rd_status", i), rd_status, tbl[i].st_rd);
      check($sformatf("tbl%0d_rd_level", i), rd_level, tbl[i].lv_rd);
      check($sformatf("tbl%0d_rd_rbin", i), rd_rbin, tbl[i].rb);
      check($sformatf("tbl%0d_wr_almost", i), wr_almost, ALM_EN && (tbl[i].lv_wr >= 4'd7));
      check($sformatf("tbl%0d_rd_almost", i), rd_almost, ALM_EN && (tbl[i].lv_rd <= 4'd1));
    end

    // Sync latency on the read side: remote 0 -> 1.
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    drive(0, 0, 0, 1, 0, 0);
    step();
    check("lat_e1_rbin", rd_rbin, 0);
    check("lat_e1_status", rd_status, 1);
    step();
    check("lat_e2_rbin", rd_rbin, 1);
    check("lat_e2_status", rd_status, 1);
    check("lat_e2_level", rd_level, 0);
    step();
    check("lat_e3_status", rd_status, 0);
    check("lat_e3_level", rd_level, 1);

    // Full detect on the write side, level 6 -> 7 -> 8.
    drive(0, 6, 7, 1, 0, 0);
    step();
    check("full_l6_status", wr_status, 0);
    check("full_l6_level", wr_level, 6);
    check("full_l6_almost", wr_almost, 0);
    drive(0, 7, 8, 1, 0, 0);
    step();
    check("full_l7_status", wr_status, 1);
    check("full_l7_level", wr_level, 7);
    check("full_l7_almost", wr_almost, ALM_EN);
    drive(0, 8, 8, 1, 0, 0);
    step();
    check("full_l8_status", wr_status, 1);
    check("full_l8_level", wr_level, 8);

    // Read side: local next meets r_sync while remote advances.
    drive(0, 8, 8, 2, 0, 1);
    step();
    check("simul_e1_status", rd_status, 1);
    step();
    check("simul_e2_status", rd_status, 1);
    step();
    check("simul_e3_status", rd_status, 0);
    check("simul_e3_level", rd_level, 2);

    // Random FIFO walk against a pointer-history model.
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n = 0; wr_bin = '0; rd_bin = '0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        #2 i_rst_n = 1'b0;
        #1 check_reset("midrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        n = 0; wr_bin = '0; rd_bin = '0;
      end
      diff   = 4'(wr_bin - rd_bin);
      wr_inc = ($urandom_range(0, 1) == 1) && (diff < 4'd8);
      rd_inc = ($urandom_range(0, 2) != 0) && (wr_bin != rd_bin);
      nxw = 4'(wr_bin + 4'(wr_inc));
      nxr = 4'(rd_bin + 4'(rd_inc));
      drive(rd_bin, wr_bin, nxw, wr_bin, rd_bin, nxr);
      hist_wr[n] = rd_bin;
      hist_rd[n] = wr_bin;
      step();
      rbw = (n >= S) ? hist_wr[n-S] : 4'd0;
      raw = (n >= S - 1) ? hist_wr[n-S+1] : 4'd0;
      rbr = (n >= S) ? hist_rd[n-S] : 4'd0;
      rar = (n >= S - 1) ? hist_rd[n-S+1] : 4'd0;
      lvw = 4'(wr_bin - rbw);
      lvr = 4'(rbr - rd_bin);
      check($sformatf("rnd%0d_wr_status", c), wr_status, 4'(nxw - rbw) == 4'd8);
      check($sformatf("rnd%0d_wr_level", c), wr_level, lvw);
      check($sformatf("rnd%0d_wr_rbin", c), wr_rbin, raw);
      check($sformatf("rnd%0d_wr_almost", c), wr_almost, ALM_EN && (lvw >= 4'(8 - T)));
      check($sformatf("rnd%0d_rd_status", c), rd_status, nxr == rbr);
      check($sformatf("rnd%0d_rd_level", c), rd_level, lvr);
      check($sformatf("rnd%0d_rd_rbin", c), rd_rbin, rar);
      check($sformatf("rnd%0d_rd_almost", c), rd_almost, ALM_EN && (lvr <= 4'(T)));
      n++;
      wr_bin = nxw;
      rd_bin = nxr;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
